wb_stage: RTL and testbench

- Writeback stage of the riscy pipeline. Sits between the MEM stage/data memory and the decode-stage register file.
- Accepts one retiring instruction per handshake, either an ALU result or a load.
- For loads, waits for the data-memory response, then extracts, aligns and sign-/zero-extends the loaded value.
- Drives the register-file write port (rd_data/rd_wren/rd_addr) as a registered single-cycle pulse. Also reports retire, load-fault and timeout events.

---
 rtl/wb_stage.sv | 178 +++++++++++++++++
 tb/tb_wb_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage of the riscy pipeline.
// Retires ALU results directly. For loads it waits for the data-memory
// response, then extracts, aligns and extends the loaded value.
// The register-file write port and the event pulses are registered so a
// negedge-written register file can capture them mid-cycle.
module wb_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_wren,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_result,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wren,
  output logic [4:0]      rd_addr,
  output logic            retire,
  output logic            load_fault,
  output logic            timeout_err
);

  // The counter only has to reach LOAD_TIMEOUT-1.
  localparam int unsigned CW = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      ld_rd_addr_q;
  logic            ld_rd_wren_q;
  logic [2:0]      ld_funct3_q;
  logic [1:0]      ld_offset_q;

  logic [XLEN-1:0] rd_data_q;
  logic            rd_wren_q;
  logic [4:0]      rd_addr_q;
  logic            retire_q;
  logic            load_fault_q;
  logic            timeout_err_q;

  logic            fault_s;
  logic [XLEN-1:0] load_val_s;

  // Misaligned halfword/word accesses and unused funct3 codes are faults.
  function automatic logic load_fault_f(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Select the addressed byte/halfword of the aligned word and extend it.
  function automatic logic [XLEN-1:0] load_extract_f(input logic [2:0] f3,
                                                     input logic [1:0] off,
                                                     input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = w[7:0];
    endcase
    if (off[1]) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  // Decode the fault condition and the aligned load value for the FSM.
  always_comb begin
    fault_s    = load_fault_f(in_funct3, in_result[1:0]);
    load_val_s = load_extract_f(ld_funct3_q, ld_offset_q, mem_rdata);
  end

  assign in_ready = (state_q == IDLE);

  // Writeback FSM: accept, wait for load data, drive registered write/events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= {CW{1'b0}};
      ld_rd_addr_q  <= 5'd0;
      ld_rd_wren_q  <= 1'b0;
      ld_funct3_q   <= 3'd0;
      ld_offset_q   <= 2'd0;
      rd_data_q     <= {XLEN{1'b0}};
      rd_wren_q     <= 1'b0;
      rd_addr_q     <= 5'd0;
      retire_q      <= 1'b0;
      load_fault_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // Event outputs are single-cycle pulses unless set below.
      rd_wren_q     <= 1'b0;
      retire_q      <= 1'b0;
      load_fault_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (!in_is_load) begin
              rd_data_q <= in_result;
              rd_addr_q <= in_rd_addr;
              rd_wren_q <= in_rd_wren && (in_rd_addr != 5'd0);
              retire_q  <= 1'b1;
            end else if (fault_s) begin
              load_fault_q <= 1'b1;
            end else begin
              ld_rd_addr_q <= in_rd_addr;
              ld_rd_wren_q <= in_rd_wren;
              ld_funct3_q  <= in_funct3;
              ld_offset_q  <= in_result[1:0];
              cnt_q        <= {CW{1'b0}};
              state_q      <= WAIT_MEM;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            // A response on the last allowed cycle still completes normally.
            rd_data_q <= load_val_s;
            rd_addr_q <= ld_rd_addr_q;
            rd_wren_q <= ld_rd_wren_q && (ld_rd_addr_q != 5'd0);
            retire_q  <= 1'b1;
            state_q   <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_wren     = rd_wren_q;
  assign rd_addr     = rd_addr_q;
  assign retire      = retire_q;
  assign load_fault  = load_fault_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a transaction-level model predicts the
// outputs every cycle, and directed vectors pin hand-computed values.
module tb_wb_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LOAD_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd_addr = 5'd0;
  logic        in_rd_wren = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_result = 32'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] rd_data;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic        retire;
  logic        load_fault;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  wb_stage #(.XLEN(XLEN), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_rd_wren(in_rd_wren), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_result(in_result), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_wren(rd_wren), .rd_addr(rd_addr),
    .retire(retire), .load_fault(load_fault), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A load is illegal for unknown funct3, or misaligned when the address is
  // not a multiple of its access size (1, 2 or 4 bytes).
  function automatic logic m_bad(input logic [2:0] f3, input logic [31:0] addr);
    int size;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    size = 1 << f3[1:0];
    return (addr % size) != 0;
  endfunction

  // Shift the addressed bytes down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * addr[1:0]);
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd4:    return {24'h0, s[7:0]};
      3'd5:    return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  logic        m_busy;
  int          m_waited;
  logic [4:0]  m_rd;
  logic        m_wr;
  logic [2:0]  m_f3;
  logic [31:0] m_addr;
  logic [31:0] e_data;
  logic [4:0]  e_addr;
  logic        e_wren, e_ret, e_fault, e_to;

  // Model: one pending load at most; counts waited cycles up to LOAD_TIMEOUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_waited <= 0;
      e_data <= 32'd0; e_addr <= 5'd0;
      e_wren <= 1'b0; e_ret <= 1'b0; e_fault <= 1'b0; e_to <= 1'b0;
    end else begin
      e_wren <= 1'b0; e_ret <= 1'b0; e_fault <= 1'b0; e_to <= 1'b0;
      if (!m_busy) begin
        if (in_valid && !in_is_load) begin
          e_data <= in_result; e_addr <= in_rd_addr;
          e_wren <= in_rd_wren && (in_rd_addr != 5'd0); e_ret <= 1'b1;
        end else if (in_valid && m_bad(in_funct3, in_result)) begin
          e_fault <= 1'b1;
        end else if (in_valid) begin
          m_busy <= 1'b1; m_waited <= 0;
          m_rd <= in_rd_addr; m_wr <= in_rd_wren; m_f3 <= in_funct3; m_addr <= in_result;
        end
      end else begin
        m_waited <= m_waited + 1;
        if (mem_rvalid) begin
          e_data <= m_load(m_f3, m_addr, mem_rdata); e_addr <= m_rd;
          e_wren <= m_wr && (m_rd != 5'd0); e_ret <= 1'b1; m_busy <= 1'b0;
        end else if (m_waited + 1 == LOAD_TIMEOUT) begin
          e_to <= 1'b1; m_busy <= 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("model rd_wren", {31'd0, rd_wren}, {31'd0, e_wren});
      chk("model retire", {31'd0, retire}, {31'd0, e_ret});
      chk("model load_fault", {31'd0, load_fault}, {31'd0, e_fault});
      chk("model timeout_err", {31'd0, timeout_err}, {31'd0, e_to});
      chk("model in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      if (e_wren) begin
        chk("model rd_data", rd_data, e_data);
        chk("model rd_addr", {27'd0, rd_addr}, {27'd0, e_addr});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [4:0] rd, input logic wr, input logic [31:0] res);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = rd; in_rd_wren = wr; in_result = res;
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a load; if it is legal, answer it after waitc cycles of waiting.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] data, input int waitc);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = f3; in_result = addr;
    in_rd_addr = rd; in_rd_wren = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    if (!m_bad(f3, addr)) begin
      chk("in_ready low in wait", {31'd0, in_ready}, 32'd0);
      repeat (waitc - 1) tick();
      mem_rvalid = 1'b1; mem_rdata = data;
      tick();
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_wren", {31'd0, rd_wren}, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Single ALU op.
    alu(5'd5, 1'b1, 32'h1234_5678);
    chk("alu rd_wren", {31'd0, rd_wren}, 32'd1);
    chk("alu rd_addr", {27'd0, rd_addr}, 32'd5);
    chk("alu rd_data", rd_data, 32'h1234_5678);
    chk("alu retire", {31'd0, retire}, 32'd1);
    tick();
    chk("alu wren drop", {31'd0, rd_wren}, 32'd0);

    // Back-to-back ALU ops, x0 in the middle.
    alu(5'd3, 1'b1, 32'h0000_0003);
    chk("b2b wren0", {31'd0, rd_wren}, 32'd1);
    alu(5'd0, 1'b1, 32'h0000_0000);
    chk("b2b wren1 x0", {31'd0, rd_wren}, 32'd0);
    chk("b2b retire1", {31'd0, retire}, 32'd1);
    alu(5'd7, 1'b1, 32'h0000_0007);
    chk("b2b wren2", {31'd0, rd_wren}, 32'd1);
    chk("b2b ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Loads with 2-cycle wait.
    do_load(3'b000, 32'h0000_1003, 5'd10, 32'h80FF_1234, 2);
    chk("LB off3", rd_data, 32'hFFFF_FF80);
    chk("LB ready after", {31'd0, in_ready}, 32'd1);
    do_load(3'b100, 32'h0000_1003, 5'd11, 32'h80FF_1234, 2);
    chk("LBU off3", rd_data, 32'h0000_0080);
    do_load(3'b101, 32'h0000_1002, 5'd12, 32'h80FF_1234, 2);
    chk("LHU off2", rd_data, 32'h0000_80FF);
    tick();

    // Faulting loads.
    do_load(3'b010, 32'h0000_1002, 5'd13, 32'h0, 1);
    chk("LW misaligned fault", {31'd0, load_fault}, 32'd1);
    chk("LW misaligned wren", {31'd0, rd_wren}, 32'd0);
    chk("LW misaligned ready", {31'd0, in_ready}, 32'd1);
    do_load(3'b011, 32'h0000_1000, 5'd13, 32'h0, 1);
    chk("funct3 011 fault", {31'd0, load_fault}, 32'd1);
    tick();

    // Sweep every funct3/offset pair with varying latency.
    for (int f = 0; f < 8; f++) begin
      for (int o = 0; o < 4; o++) begin
        do_load(3'(f), 32'h0000_2000 + 32'(o), 5'(f * 4 + o), 32'h8421_F0E7, 1 + (o % 3));
      end
    end
    tick();

    // Timeout: exactly one pulse, 16 cycles after accept.
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_result = 32'h0000_3000;
    in_rd_addr = 5'd9; in_rd_wren = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (timeout_err) pulses++;
      if (k == 15) chk("timeout not yet", {31'd0, timeout_err}, 32'd0);
    end
    chk("timeout at 16", {31'd0, timeout_err}, 32'd1);
    chk("timeout once", 32'(pulses), 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("late rvalid no write", {31'd0, rd_wren}, 32'd0);
    tick();

    // Response on the final wait cycle wins over the timeout.
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_result = 32'h0000_3004;
    in_rd_addr = 5'd9; in_rd_wren = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    repeat (15) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_rvalid = 1'b0;
    chk("last-cycle write", {31'd0, rd_wren}, 32'd1);
    chk("last-cycle data", rd_data, 32'hCAFE_0001);
    chk("last-cycle no timeout", {31'd0, timeout_err}, 32'd0);
    tick();

    // Reset during WAIT_MEM abandons the load.
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_result = 32'h0000_3008;
    in_rd_addr = 5'd14; in_rd_wren = 1'b1;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset rd_data", rd_data, 32'd0);
    chk("mid reset rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("mid reset ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    chk("post reset no write", {31'd0, rd_wren}, 32'd0);
    chk("post reset no retire", {31'd0, retire}, 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
